derivative_sched: RTL and testbench



---
 rtl/derivative_sched_pkg.sv | 24 ++
 rtl/derivative_sched_if.sv | 28 ++
 rtl/derivative_sched_rr_arbiter.sv | 43 ++++
 rtl/derivative_sched.sv | 168 ++++++++++++++++
 tb/tb_derivative_sched.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/derivative_sched_pkg.sv
// Shared definitions for the derivative scheduler: FSM state encoding,
// default scale constant and the channel-index width helper.
package derivative_pkg;

    // FSM state encoding (legacy-compatible constants)
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_SUB  = 2'd1;
    localparam state_t S_MUL  = 2'd2;
    localparam state_t S_OUT  = 2'd3;

    // Default multiplier applied to every channel difference
    localparam logic [7:0] DEFAULT_SCALE = 8'd180;

    // Width of a channel index; never narrower than one bit
    function automatic int ch_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/derivative_sched_if.sv
// Requester/consumer bundle of the derivative scheduler.
// master: sample sources and result consumers; slave: the scheduler itself.
interface derivative_sched_if #(
    parameter int NCH   = 4,
    parameter int Nbits = 2,
    parameter int Obits = 9
);
    localparam int CW = derivative_pkg::ch_width(NCH);

    logic [NCH-1:0]           req;
    logic [NCH*(Nbits+1)-1:0] sample_in;
    logic [NCH-1:0]           grant;
    logic                     busy;
    logic                     out_valid;
    logic [CW-1:0]            out_ch;
    logic [Obits:0]           out_der;

    modport master (
        output req, sample_in,
        input  grant, busy, out_valid, out_ch, out_der
    );

    modport slave (
        input  req, sample_in,
        output grant, busy, out_valid, out_ch, out_der
    );

endinterface

// File: rtl/derivative_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting channel
// at or after ptr_i, wrapping around. Outputs are zero when nobody requests.
module rr_arbiter
    import derivative_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int CW  = ch_width(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [CW-1:0]  ptr_i,
    output logic [NCH-1:0] grant_o,
    output logic [CW-1:0]  idx_o
);

    // Scan channels starting at the pointer; first hit wins
    always_comb begin
        logic          found;
        int            cand;
        logic [CW-1:0] cand_idx;
        grant_o  = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 0; off < NCH; off++) begin
            cand = int'(ptr_i) + off;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end else begin
                cand = cand;
            end
            cand_idx = CW'(cand);
            if (!found && req_i[cand_idx]) begin
                found             = 1'b1;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/derivative_sched.sv
// Time-multiplexed center-derivative engine: one round-robin-granted channel
// at a time runs IDLE -> SUB -> MUL -> OUT (grant at T, result at T+3).
// Optional build macro DER_SATURATE_EN: clamp out_der to all ones on
// product overflow instead of dropping the upper bits.
module derivative_sched
    import derivative_pkg::*;
#(
    parameter int         NCH   = 4,
    parameter int         Nbits = 2,
    parameter int         Obits = 9,
    parameter logic [7:0] SCALE = DEFAULT_SCALE
) (
    input  logic                clk,
    input  logic                rst_n,
    derivative_sched_if.slave   bus
);

    localparam int SW = Nbits + 1;              // sample width
    localparam int OW = Obits + 1;              // output width
    localparam int PW = Nbits + 9;              // full product width
    localparam int MW = (PW > OW) ? PW : OW;    // common compare width
    localparam int CW = ch_width(NCH);

    state_t         state_q, state_d;
    logic [CW-1:0]  ptr_q;
    logic [CW-1:0]  ch_q;
    logic [SW-1:0]  cur_q;
    logic [SW-1:0]  diff_q;
    logic [SW-1:0]  prev_q [NCH];
    logic           out_valid_q;
    logic [CW-1:0]  out_ch_q;
    logic [OW-1:0]  out_der_q;

    logic [NCH-1:0] arb_grant_s;
    logic [CW-1:0]  arb_idx_s;
    logic           any_req_s;
    logic [SW-1:0]  sel_sample_s;
    logic [PW-1:0]  prod_full_s;
    logic [OW-1:0]  prod_s;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant_s),
        .idx_o   (arb_idx_s)
    );

    assign any_req_s = |bus.req;

    // Sample of the channel the arbiter currently selects
    always_comb begin
        sel_sample_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (arb_idx_s == CW'(i)) begin
                sel_sample_s = bus.sample_in[i*SW +: SW];
            end else begin
                sel_sample_s = sel_sample_s;
            end
        end
    end

    // Full-width product of the registered difference and the scale
    assign prod_full_s = PW'(diff_q) * PW'(SCALE);

`ifdef DER_SATURATE_EN
    localparam logic [MW-1:0] OMAX_EXT = MW'({OW{1'b1}});
    assign prod_s = (MW'(prod_full_s) > OMAX_EXT) ? {OW{1'b1}} : OW'(prod_full_s);
`else
    assign prod_s = OW'(prod_full_s);
`endif

    // Next-state logic; req only matters while IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req_s) begin
                    state_d = S_SUB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SUB:   state_d = S_MUL;
            S_MUL:   state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture granted sample and channel in the IDLE grant cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q <= '0;
            ch_q  <= '0;
        end else if (state_q == S_IDLE && any_req_s) begin
            cur_q <= sel_sample_s;
            ch_q  <= arb_idx_s;
        end else begin
            cur_q <= cur_q;
            ch_q  <= ch_q;
        end
    end

    // SUB stage: wrapping difference and round-robin pointer advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= '0;
            ptr_q  <= '0;
        end else if (state_q == S_SUB) begin
            diff_q <= cur_q - prev_q[ch_q];
            if (ch_q == CW'(NCH - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ch_q + CW'(1);
            end
        end else begin
            diff_q <= diff_q;
            ptr_q  <= ptr_q;
        end
    end

    // Per-channel previous-sample storage, updated in SUB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                prev_q[i] <= '0;
            end
        end else if (state_q == S_SUB) begin
            prev_q[ch_q] <= cur_q;
        end else begin
            prev_q <= prev_q;
        end
    end

    // The product is registered straight into the output register so that
    // out_der/out_ch are already valid during the OUT cycle with out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_der_q   <= '0;
        end else if (state_q == S_MUL) begin
            out_valid_q <= 1'b1;
            out_ch_q    <= ch_q;
            out_der_q   <= prod_s;
        end else begin
            out_valid_q <= 1'b0;
            out_ch_q    <= out_ch_q;
            out_der_q   <= out_der_q;
        end
    end

    assign bus.grant     = (state_q == S_IDLE) ? arb_grant_s : '0;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_der   = out_der_q;

endmodule

// File: tb/tb_derivative_sched.sv
// Self-checking bench for derivative_sched: a cycle-timed behavioural model
// (grant at T, result at T+3, next grant no earlier than T+4) checked every
// cycle, plus directed operations with hand-computed literal results.
module tb_derivative_sched;
    localparam int NCH   = 4;
    localparam int Nbits = 2;
    localparam int Obits = 9;
    localparam int SW    = Nbits + 1;
    localparam int SCL   = 180;
    localparam int OMAX  = (1 << (Obits + 1)) - 1;

    logic clk;
    logic rst_n;

    derivative_sched_if #(.NCH(NCH), .Nbits(Nbits), .Obits(Obits)) bus ();

    derivative_sched #(.NCH(NCH), .Nbits(Nbits), .Obits(Obits), .SCALE(8'd180)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scaled difference from the rules: wrap the difference, multiply,
    // then either clamp or keep the low output bits.
    function automatic int der_of(input int cur, input int prev);
        int d;
        int p;
        d = (cur - prev) & ((1 << SW) - 1);
        p = d * SCL;
`ifdef DER_SATURATE_EN
        if (p > OMAX) p = OMAX;
`else
        p = p & OMAX;
`endif
        return p;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    int m_prev [NCH];
    int m_ptr, cyc, grant_cyc, next_free, res_cyc;
    int pend_ch, pend_der, last_ch, last_der;

    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                for (int i = 0; i < NCH; i++) m_prev[i] = 0;
                m_ptr = 0; grant_cyc = -100; next_free = 0; res_cyc = -1;
                last_ch = 0; last_der = 0; pend_ch = 0; pend_der = 0;
                check("rst_grant", bus.grant, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_valid", bus.out_valid, 0);
                check("rst_ch", bus.out_ch, 0);
                check("rst_der", bus.out_der, 0);
            end else begin
                int k;
                int exp_grant;
                int exp_valid;
                exp_grant = 0;
                k = -1;
                if (cyc >= next_free) begin
                    for (int o = 0; o < NCH; o++) begin
                        int c;
                        c = (m_ptr + o) % NCH;
                        if (k < 0 && bus.req[c]) k = c;
                    end
                end
                if (k >= 0) begin
                    int smp;
                    smp = int'(bus.sample_in[k*SW +: SW]);
                    exp_grant = 1 << k;
                    pend_ch = k;
                    pend_der = der_of(smp, m_prev[k]);
                    m_prev[k] = smp;
                    m_ptr = (k + 1) % NCH;
                    grant_cyc = cyc;
                    res_cyc = cyc + 3;
                    next_free = cyc + 4;
                end
                exp_valid = (cyc == res_cyc) ? 1 : 0;
                if (exp_valid == 1) begin
                    last_ch = pend_ch;
                    last_der = pend_der;
                end
                check("grant", bus.grant, exp_grant);
                check("busy", bus.busy, (cyc > grant_cyc && cyc < next_free) ? 1 : 0);
                check("out_valid", bus.out_valid, exp_valid);
                check("out_ch", bus.out_ch, last_ch);
                check("out_der", bus.out_der, last_der);
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------
    task automatic op(input int ch, input int smp, input int exp_der, input string nm);
        bit seen;
        int lat;
        @(posedge clk); #1;
        bus.sample_in[ch*SW +: SW] = SW'(smp);
        bus.req = NCH'(1) << ch;
        seen = 1'b0;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(negedge clk);
            if (bus.grant != '0) seen = 1'b1;
        end
        check({nm, "_grant"}, seen ? int'(bus.grant) : 0, 1 << ch);
        @(posedge clk); #1;
        bus.req = '0;
        bus.sample_in = ~bus.sample_in;   // must not disturb the in-flight op
        seen = 1'b0;
        lat = 1;
        for (int n = 1; n <= 8 && !seen; n++) begin
            @(negedge clk);
            lat = n;
            if (bus.out_valid) seen = 1'b1;
        end
        check({nm, "_latency"}, seen ? lat : -1, 3);
        check({nm, "_ch"}, bus.out_ch, ch);
        check({nm, "_der"}, bus.out_der, exp_der);
    endtask

    initial begin
        bit seen;
        int gap;
        int vcount;
        rst_n = 1'b0;
        bus.req = '0;
        bus.sample_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_der", bus.out_der, 0);

        op(0, 3, 540, "ch0_first");
        op(0, 5, 360, "ch0_second");
`ifdef DER_SATURATE_EN
        op(1, 6, 1023, "ch1_first");
`else
        op(1, 6, 56, "ch1_first");
`endif
        op(1, 1, 540, "ch1_wrap");
`ifdef DER_SATURATE_EN
        op(2, 7, 1023, "ch2_ovf");
`else
        op(2, 7, 236, "ch2_ovf");
`endif

        // Reset in the MUL cycle aborts the op and clears prev[0]
        @(posedge clk); #1;
        bus.sample_in[0 +: SW] = 3'd4;
        bus.req = 4'b0001;
        seen = 1'b0;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(negedge clk);
            if (bus.grant != '0) seen = 1'b1;
        end
        check("abort_grant", seen ? int'(bus.grant) : 0, 1);
        @(posedge clk); #1 bus.req = '0;       // SUB cycle
        @(posedge clk); #2 rst_n = 1'b0;       // inside MUL cycle
        @(negedge clk);
        check("abort_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_der", bus.out_der, 0);
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        vcount = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus.out_valid) vcount++;
        end
        check("abort_no_result", vcount, 0);
        op(0, 2, 360, "after_reset");
        op(3, 1, 180, "ch3_first");            // pointer now back to channel 0

        // Fairness: all channels held high
        @(posedge clk); #1;
        bus.sample_in = {3'd7, 3'd2, 3'd6, 3'd5};
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            seen = 1'b0;
            gap = 0;
            for (int n = 1; n <= 8 && !seen; n++) begin
                @(negedge clk);
                gap = n;
                if (bus.grant != '0) seen = 1'b1;
            end
            check("fair_grant", seen ? int'(bus.grant) : 0, 1 << (i % NCH));
            if (i > 0) check("fair_spacing", gap, 4);
        end
        @(posedge clk); #1 bus.req = '0;
        repeat (8) @(negedge clk);

        // Single requester held high: granted every 4 cycles
        @(posedge clk); #1 bus.req = 4'b0100;
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk);
            if (bus.grant != '0) seen = 1'b1;
        end
        check("single_first", seen ? int'(bus.grant) : 0, 4);
        seen = 1'b0;
        gap = 0;
        for (int n = 1; n <= 8 && !seen; n++) begin
            @(negedge clk);
            gap = n;
            if (bus.grant != '0) seen = 1'b1;
        end
        check("single_spacing", seen ? gap : -1, 4);
        @(posedge clk); #1 bus.req = '0;
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
